// File: rtl/pkg_sorter_defs.sv
// Shared definitions for the package sorter weight path: default bus width,
// group bin bounds, group codes, the feeder FSM encoding and the bin lookup.
package pkg_sorter_defs;

  localparam int WEIGHT_W = 12;

  // Upper (inclusive) bound of each sorter bin; anything above BIN5_MAX is group 6.
  localparam logic [31:0] BIN1_MAX = 32'd200;
  localparam logic [31:0] BIN2_MAX = 32'd500;
  localparam logic [31:0] BIN3_MAX = 32'd800;
  localparam logic [31:0] BIN4_MAX = 32'd1000;
  localparam logic [31:0] BIN5_MAX = 32'd2000;

  localparam logic [2:0] GRP_NONE = 3'd0;
  localparam logic [2:0] GRP1     = 3'd1;
  localparam logic [2:0] GRP2     = 3'd2;
  localparam logic [2:0] GRP3     = 3'd3;
  localparam logic [2:0] GRP4     = 3'd4;
  localparam logic [2:0] GRP5     = 3'd5;
  localparam logic [2:0] GRP6     = 3'd6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  // Sorter bin of a weight; zero means "no package" and maps to GRP_NONE.
  function automatic logic [2:0] grp_of(input logic [31:0] w);
    if (w == 32'd0)          return GRP_NONE;
    else if (w <= BIN1_MAX)  return GRP1;
    else if (w <= BIN2_MAX)  return GRP2;
    else if (w <= BIN3_MAX)  return GRP3;
    else if (w <= BIN4_MAX)  return GRP4;
    else if (w <= BIN5_MAX)  return GRP5;
    else                     return GRP6;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO between the upstream producer and the feeder FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Read data is the current head (show-ahead), valid whenever empty is low.
module feeder_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  import pkg_sorter_defs::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care while empty, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; a simultaneous push and pop moves both and leaves occupancy unchanged.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/package_feeder.sv
// Weight-bus driver for the package sorter: queues producer weights and
// presents each one for HOLD_CYC cycles followed by GAP_CYC cycles of zero.
// Optional build macro PKG_FEEDER_PREDICT_EN adds the expected-group output
// exp_grp and per-group sent counters exp_cnt1..exp_cnt6.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus at 0; pops the FIFO head as soon as one is available
// PRESENT | bus holds the popped weight until the hold counter expires
// GAP     | bus at 0 until the gap counter expires, then back to IDLE
module package_feeder #(
  parameter int WEIGHT_W = pkg_sorter_defs::WEIGHT_W,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WEIGHT_W-1:0] weight,
  output logic                busy,
  output logic [7:0]          sent_count,
  output logic                zero_drop
`ifdef PKG_FEEDER_PREDICT_EN
  ,
  output logic [2:0]          exp_grp,
  output logic [7:0]          exp_cnt1,
  output logic [7:0]          exp_cnt2,
  output logic [7:0]          exp_cnt3,
  output logic [7:0]          exp_cnt4,
  output logic [7:0]          exp_cnt5,
  output logic [7:0]          exp_cnt6
`endif
);
  import pkg_sorter_defs::*;

  // One counter serves both the hold and the gap phase; it only ever needs
  // to hold max(HOLD_CYC, GAP_CYC) - 1.
  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                push;
  logic                pop;
  logic                phase_done;
  logic [WEIGHT_W-1:0] head;

  // A zero beat is handshaken normally but never enters the queue.
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_weight != '0);
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign phase_done = (cnt == '0);
  assign busy       = !fifo_empty || (state != ST_IDLE);

  feeder_fifo #(
    .W     (WEIGHT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (in_weight),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bus sequencing: present, hold, gap, and count every package put on the bus.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      weight     <= '0;
      sent_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            weight     <= head;
            sent_count <= sent_count + 8'd1;
            cnt        <= CNT_W'(HOLD_CYC - 1);
            state      <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (phase_done) begin
            weight <= '0;
            cnt    <= CNT_W'(GAP_CYC - 1);
            state  <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (phase_done) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          weight <= '0;
          cnt    <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Flag a discarded zero beat on the cycle after it was accepted.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= accept && (in_weight == '0);
    end
  end

`ifdef PKG_FEEDER_PREDICT_EN
  logic [2:0] head_grp;
  logic [7:0] exp_cnt_r [6];

  assign head_grp = grp_of(32'(head));

  assign exp_cnt1 = exp_cnt_r[0];
  assign exp_cnt2 = exp_cnt_r[1];
  assign exp_cnt3 = exp_cnt_r[2];
  assign exp_cnt4 = exp_cnt_r[3];
  assign exp_cnt5 = exp_cnt_r[4];
  assign exp_cnt6 = exp_cnt_r[5];

  // Expected group tracks the bus: loaded with the popped weight, cleared with it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      exp_grp <= GRP_NONE;
    end else if (pop) begin
      exp_grp <= head_grp;
    end else if ((state == ST_PRESENT) && phase_done) begin
      exp_grp <= GRP_NONE;
    end
  end

  // Per-group package counters, bumped on entry to PRESENT.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 6; i++) exp_cnt_r[i] <= 8'd0;
    end else if (pop) begin
      for (int i = 0; i < 6; i++) begin
        if (head_grp == 3'(i + 1)) exp_cnt_r[i] <= exp_cnt_r[i] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_package_feeder.sv
module tb_package_feeder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [11:0] in_weight;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] weight;
  logic        busy;
  logic [7:0]  sent_count;
  logic        zero_drop;
`ifdef PKG_FEEDER_PREDICT_EN
  logic [2:0]  exp_grp;
  logic [7:0]  exp_cnt1, exp_cnt2, exp_cnt3, exp_cnt4, exp_cnt5, exp_cnt6;
`endif

  int vectors = 0;
  int miscompares = 0;

  int src_q[$];
  int got_q[$];
  int grp_q[$];
  int glitches;
  bit stalled;
  bit done;

  package_feeder dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .in_weight  (in_weight),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .weight     (weight),
    .busy       (busy),
    .sent_count (sent_count),
    .zero_drop  (zero_drop)
`ifdef PKG_FEEDER_PREDICT_EN
    ,
    .exp_grp    (exp_grp),
    .exp_cnt1   (exp_cnt1),
    .exp_cnt2   (exp_cnt2),
    .exp_cnt3   (exp_cnt3),
    .exp_cnt4   (exp_cnt4),
    .exp_cnt5   (exp_cnt5),
    .exp_cnt6   (exp_cnt6)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    in_valid = 1'b0;
    in_weight = 12'd0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Drives src_q with in_valid held high, records each package as it rises on the bus.
  task automatic run_stream(input int budget);
    int idx;
    int prev;
    bit acc;
    idx = 0; prev = 0; glitches = 0; stalled = 0; done = 0;
    got_q = {}; grp_q = {};
    for (int c = 0; c < budget; c++) begin
      if (idx < src_q.size()) begin
        in_valid = 1'b1;
        in_weight = 12'(src_q[idx]);
      end else begin
        in_valid = 1'b0;
        in_weight = 12'd0;
      end
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalled = 1'b1;
      tick();
      if (acc) idx++;
      if (weight != 12'd0 && prev == 0) begin
        got_q.push_back(int'(weight));
`ifdef PKG_FEEDER_PREDICT_EN
        grp_q.push_back(int'(exp_grp));
`endif
      end
      if (weight != 12'd0 && prev != 0 && int'(weight) != prev) glitches++;
      prev = int'(weight);
      if (idx == src_q.size() && !busy) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_weight = 12'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    in_valid = 1'b0;
    in_weight = 12'd0;
    tick();
    tick();
    vectors++; if (weight !== 12'd0) begin miscompares++; $display("FAIL reset_weight: got %0d expected 0", weight); end
    vectors++; if (sent_count !== 8'd0) begin miscompares++; $display("FAIL reset_sent_count: got %0d expected 0", sent_count); end
    vectors++; if (zero_drop !== 1'b0) begin miscompares++; $display("FAIL reset_zero_drop: got %0b expected 0", zero_drop); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
`ifdef PKG_FEEDER_PREDICT_EN
    vectors++; if (exp_grp !== 3'd0) begin miscompares++; $display("FAIL reset_exp_grp: got %0d expected 0", exp_grp); end
`endif
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int in_w[4] = '{250, 300, 501, 1013};
    int exp_w[22] = '{0, 250, 250, 0, 0, 0, 300, 300, 0, 0, 0,
                      501, 501, 0, 0, 0, 1013, 1013, 0, 0, 0, 0};
    int exp_g[22] = '{0, 2, 2, 0, 0, 0, 2, 2, 0, 0, 0,
                      3, 3, 0, 0, 0, 5, 5, 0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_weight = 12'(in_w[i]);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL nominal_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
        in_weight = 12'd0;
      end
      tick();
      vectors++; if (weight !== 12'(exp_w[i])) begin miscompares++; $display("FAIL nominal_weight[%0d]: got %0d expected %0d", i, weight, exp_w[i]); end
`ifdef PKG_FEEDER_PREDICT_EN
      vectors++; if (exp_grp !== 3'(exp_g[i])) begin miscompares++; $display("FAIL nominal_exp_grp[%0d]: got %0d expected %0d", i, exp_grp, exp_g[i]); end
`else
      if (exp_g[i] < 0) $display("unexpected table entry");
`endif
    end
    vectors++; if (sent_count !== 8'd4) begin miscompares++; $display("FAIL nominal_sent_count: got %0d expected 4", sent_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nominal_busy_end: got %0b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    src_q = '{10, 20, 30, 40, 50, 60};
    run_stream(200);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_timeout: got done=%0b expected 1", done); end
    vectors++; if (stalled !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_drop: got stalled=%0b expected 1", stalled); end
    vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL bp_count: got %0d packages expected 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      vectors++; if (got_q[k] != src_q[k]) begin miscompares++; $display("FAIL bp_order[%0d]: got %0d expected %0d", k, got_q[k], src_q[k]); end
    end
    vectors++; if (glitches != 0) begin miscompares++; $display("FAIL bp_gap: got %0d direct changes expected 0", glitches); end
    vectors++; if (sent_count !== 8'd6) begin miscompares++; $display("FAIL bp_sent_count: got %0d expected 6", sent_count); end
  endtask

  task automatic test_zero_beat();
    int zd_cnt;
    int rises;
    int prev;
    apply_reset();
    in_valid = 1'b1;
    in_weight = 12'd0;
    tick();
    zd_cnt = (zero_drop === 1'b1) ? 1 : 0;
    vectors++; if (zero_drop !== 1'b1) begin miscompares++; $display("FAIL zero_drop_pulse: got %0b expected 1", zero_drop); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_not_stored: got busy=%0b expected 0", busy); end
    in_weight = 12'd700;
    tick();
    in_valid = 1'b0;
    in_weight = 12'd0;
    if (zero_drop === 1'b1) zd_cnt++;
    vectors++; if (zero_drop !== 1'b0) begin miscompares++; $display("FAIL zero_drop_clear: got %0b expected 0", zero_drop); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_then_700_busy: got %0b expected 1", busy); end
    tick();
    vectors++; if (weight !== 12'd700) begin miscompares++; $display("FAIL zero_then_700_weight: got %0d expected 700", weight); end
    rises = 0;
    prev = int'(weight);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (zero_drop === 1'b1) zd_cnt++;
      if (weight != 12'd0 && prev == 0) rises++;
      prev = int'(weight);
    end
    vectors++; if (zd_cnt != 1) begin miscompares++; $display("FAIL zero_drop_count: got %0d expected 1", zd_cnt); end
    vectors++; if (rises != 0) begin miscompares++; $display("FAIL zero_extra_packages: got %0d expected 0", rises); end
    vectors++; if (sent_count !== 8'd1) begin miscompares++; $display("FAIL zero_sent_count: got %0d expected 1", sent_count); end
  endtask

  task automatic test_reset_mid();
    int in_w[3] = '{501, 600, 700};
    int nz;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_weight = 12'(in_w[i]);
      tick();
    end
    in_valid = 1'b0;
    in_weight = 12'd0;
    vectors++; if (weight !== 12'd501) begin miscompares++; $display("FAIL mid_present_weight: got %0d expected 501", weight); end
    Reset = 1'b1;
    #1;
    vectors++; if (weight !== 12'd0) begin miscompares++; $display("FAIL mid_async_weight: got %0d expected 0", weight); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_async_busy: got %0b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_async_in_ready: got %0b expected 1", in_ready); end
    #1;
    Reset = 1'b0;
    nz = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (weight != 12'd0) nz++;
    end
    vectors++; if (nz != 0) begin miscompares++; $display("FAIL mid_residual: got %0d nonzero cycles expected 0", nz); end
    vectors++; if (sent_count !== 8'd0) begin miscompares++; $display("FAIL mid_sent_count: got %0d expected 0", sent_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_wrap();
    int bad;
    apply_reset();
    src_q = {};
    for (int k = 0; k < 257; k++) src_q.push_back(((k * 13) % 4000) + 1);
    run_stream(1500);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_timeout: got done=%0b expected 1", done); end
    vectors++; if (got_q.size() != 257) begin miscompares++; $display("FAIL wrap_count: got %0d packages expected 257", got_q.size()); end
    bad = 0;
    for (int k = 0; k < 257 && k < got_q.size(); k++) if (got_q[k] != src_q[k]) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL wrap_order: got %0d out-of-order packages expected 0", bad); end
    vectors++; if (glitches != 0) begin miscompares++; $display("FAIL wrap_gap: got %0d direct changes expected 0", glitches); end
    vectors++; if (sent_count !== 8'd1) begin miscompares++; $display("FAIL wrap_sent_count: got %0d expected 1", sent_count); end
  endtask

`ifdef PKG_FEEDER_PREDICT_EN
  task automatic test_bins();
    int exp_g[6] = '{1, 2, 4, 5, 5, 6};
    apply_reset();
    src_q = '{200, 201, 1000, 1001, 2000, 2001};
    run_stream(200);
    vectors++; if (grp_q.size() != 6) begin miscompares++; $display("FAIL bins_count: got %0d expected 6", grp_q.size()); end
    for (int k = 0; k < 6 && k < grp_q.size(); k++) begin
      vectors++; if (grp_q[k] != exp_g[k]) begin miscompares++; $display("FAIL bins_grp[%0d]: got %0d expected %0d", k, grp_q[k], exp_g[k]); end
    end
    vectors++; if (exp_grp !== 3'd0) begin miscompares++; $display("FAIL bins_grp_idle: got %0d expected 0", exp_grp); end
    vectors++; if (exp_cnt1 !== 8'd1) begin miscompares++; $display("FAIL bins_cnt1: got %0d expected 1", exp_cnt1); end
    vectors++; if (exp_cnt2 !== 8'd1) begin miscompares++; $display("FAIL bins_cnt2: got %0d expected 1", exp_cnt2); end
    vectors++; if (exp_cnt3 !== 8'd0) begin miscompares++; $display("FAIL bins_cnt3: got %0d expected 0", exp_cnt3); end
    vectors++; if (exp_cnt4 !== 8'd1) begin miscompares++; $display("FAIL bins_cnt4: got %0d expected 1", exp_cnt4); end
    vectors++; if (exp_cnt5 !== 8'd2) begin miscompares++; $display("FAIL bins_cnt5: got %0d expected 2", exp_cnt5); end
    vectors++; if (exp_cnt6 !== 8'd1) begin miscompares++; $display("FAIL bins_cnt6: got %0d expected 1", exp_cnt6); end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0;
    in_weight = 12'd0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero_beat();
    test_reset_mid();
    test_wrap();
`ifdef PKG_FEEDER_PREDICT_EN
    test_bins();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/package_feeder.md
Name: package_feeder

Overview:
- Transmit-side driver for the package sorter's weight bus. It turns a queued stream of package weights into the waveform the sorter consumes.
- Each package is presented as a nonzero weight for HOLD_CYC cycles, then the bus is driven to 0 for GAP_CYC cycles so that every package is a distinct event.
- A small FIFO decouples the upstream valid/ready producer from bus timing.
- The block sits between a host or stimulus source and the sorter's weight input. It also drives a sent-package counter for cross-checking the sorter's group totals.

Parameters:
- WEIGHT_W, 12, width of a package weight.
- DEPTH, 4, FIFO entries (power of 2, >=2).
- HOLD_CYC, 2, cycles a weight is held on the bus (>=1).
- GAP_CYC, 2, cycles of 0 weight after each package (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_weight  in  WEIGHT_W  package weight offered by the producer.
- in_valid  in  1  in_weight is valid.
- in_ready  out  1  FIFO can accept a beat.
- weight  out  WEIGHT_W  registered weight bus to the sorter.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- sent_count  out  8  packages presented since reset.
- zero_drop  out  1  one-cycle pulse: a zero-weight beat was discarded.

Behaviour:
- Interface fixed: one clock CLK; Reset is asynchronous and active-high.
- Reset values:
  - weight=0, sent_count=0, zero_drop=0, busy=0, in_ready=1.
  - FIFO empty, FSM in IDLE.
  - A reset asserted mid-operation forces weight=0 immediately (async) and discards all queued beats.
- Upstream handshake:
  - A beat is accepted when in_valid && in_ready at a CLK edge. in_ready = !fifo_full (combinational).
  - No bypass: a full FIFO stalls even if a pop occurs in the same cycle.
  - in_weight==0 is accepted but not stored, because 0 means "no package" on the bus. zero_drop pulses high on the cycle after acceptance.
- FSM states:
  - IDLE: weight=0. If FIFO is non-empty → pop the head, weight<=head, sent_count<=sent_count+1 (wraps 255→0), hold counter<=HOLD_CYC-1, go to PRESENT.
  - PRESENT: weight is held. When the hold counter reaches 0 → weight<=0, gap counter<=GAP_CYC-1, go to GAP. Otherwise decrement the counter.
  - GAP: weight=0. When the gap counter reaches 0 → go to IDLE. Otherwise decrement the counter.
- Timing:
  - Latency from acceptance (empty FIFO, IDLE) to weight visible: 2 edges (push edge, then pop edge).
  - Period per package: HOLD_CYC+GAP_CYC+1 cycles (IDLE costs 1 cycle).
- Simultaneous push and pop on a non-full FIFO are both honoured. The occupancy count stays unchanged.
- weight never changes directly from one nonzero value to another; a gap always separates packages.

Optional Feature:
- Macro: PKG_FEEDER_PREDICT_EN.
- When defined:
  - Adds output exp_grp[2:0], registered alongside weight.
  - exp_grp is 0 when weight is 0. Otherwise it is the sorter bin of weight: 1–200→1, 201–500→2, 501–800→3, 801–1000→4, 1001–2000→5, >2000→6.
  - Adds per-group counters exp_cnt1..exp_cnt6[7:0], each incremented on entry to PRESENT and wrapping at 255.
- When undefined: none of these ports or registers exist.

Decomposition:
- Shared package pkg_sorter_defs:
  - WEIGHT_W.
  - Group bin bound constants 200/500/800/1000/2000.
  - Group code localparams (GRP_NONE=0 … GRP6=6).
  - FSM state encoding (IDLE/PRESENT/GAP).
- Sub-module feeder_fifo: synchronous FIFO with async reset.
  - Ports: CLK, Reset, push, pop, din, dout, full, empty.
  - Pointers are log2(DEPTH)+1 bits wide.

Test Plan:
- Nominal sequence: push 250,300,501,1013 back-to-back with defaults → weight shows 250 for 2 cycles, 0 for 3, 300 for 2, and so on. sent_count ends at 4. With predict enabled, exp_grp sequence is 2,2,3,5.
- Backpressure: hold in_valid high with 6 beats while the bus is busy → in_ready drops after the FIFO fills. No beat is lost or duplicated, and the output order matches input order.
- Zero beat: push 0 then 700 → zero_drop pulses once, only 700 appears on weight, sent_count=1.
- Reset mid-PRESENT: assert Reset while weight=501 with 2 beats queued → weight=0 immediately. After release, no residual packages; sent_count=0, busy=0.
- Wrap: send 257 packages → sent_count=1. weight returns to 0 between every pair.
- Boundary bins (predict enabled): weights 200,201,1000,1001,2000,2001 → exp_grp 1,2,4,5,5,6.
